// File: rtl/sram_b_stream_pkg.sv
// Shared types and default widths for the sram_b burst read engine.
package sram_b_stream_pkg;

    localparam int SRAM_B_ADDR_W = 18;
    localparam int SRAM_B_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // One buffered read word together with its end-of-burst marker.
    typedef struct packed {
        logic                     last;
        logic [SRAM_B_DATA_W-1:0] data;
    } rd_entry_t;

endpackage

// File: rtl/sram_b_rd_fifo.sv
// Synchronous first-word-fall-through FIFO. When empty, a pushed word is
// visible on the output in the same cycle, so push+pop at empty passes the
// word straight through without changing the count.
module sram_b_rd_fifo
    import sram_b_stream_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk_sys_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop     = pop_i && ((count_q != '0) || push_i);
    assign empty_o    = (count_q == '0) && !push_i;
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = (count_q == '0) ? push_data_i : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_sys_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Overflow is impossible if the producer honours its credit limit.
    assert property (@(posedge clk_sys_i) disable iff (rst_i) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/sram_b_rd_stream.sv
// Burst read engine for the sram_b read port: issues credit-gated reads,
// captures Q1 one cycle later and streams words out with a last marker.
//
// state | meaning
// IDLE  | ready for a request; zero-length request only pulses done
// ISSUE | one read per cycle while buffer credit is available
// DRAIN | all reads issued; wait for the last beat to be taken
module sram_b_rd_stream
    import sram_b_stream_pkg::*;
#(
    parameter int ADDR_W     = SRAM_B_ADDR_W,
    parameter int DATA_W     = SRAM_B_DATA_W,
    parameter int LEN_W      = ADDR_W + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              CE1,
    output logic [ADDR_W-1:0] A1,
    input  logic [DATA_W-1:0] Q1
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inflight_q, last_tag_q, done_q, done_d;
    logic              issue, issue_last, credit, pop;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    rd_entry_t         push_entry, pop_entry;

    // Credit counts the read still in the SRAM pipe so the buffer can never overflow.
    assign credit = !fifo_full && ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH);

    assign req_ready  = (state_q == IDLE) && !RST;
    assign CE1        = issue;
    assign A1         = addr_q;
    assign done       = done_q;
    assign out_valid  = !fifo_empty;
    assign out_data   = pop_entry.data;
    assign out_last   = pop_entry.last;
    assign pop        = out_valid && out_ready;
    assign push_entry = '{last: last_tag_q, data: Q1};

    // Next-state, read issue and completion decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        rem_d   = req_len;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        issue_last = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, burst counters and the one-cycle read pipeline stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            last_tag_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= issue;
            last_tag_q <= issue_last;
            done_q     <= done_d;
        end
    end

    sram_b_rd_fifo #(
        .WIDTH ($bits(rd_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys_i   (CLK),
        .rst_i       (RST),
        .push_i      (inflight_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .pop_data_o  (pop_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_sram_b_rd_stream.sv
// Bench for sram_b_rd_stream: directed burst table, corner sequences and
// random bursts against a queue-based model of the expected read stream.
module tb_sram_b_rd_stream;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 19;
    localparam int DEPTH  = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              out_valid, out_ready, out_last, done, CE1;
    logic [DATA_W-1:0] out_data, Q1;
    logic [ADDR_W-1:0] A1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sram_b_rd_stream #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .done(done), .CE1(CE1), .A1(A1), .Q1(Q1)
    );

    function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {2'b00, a[17:12]};
    endfunction

    // SRAM read port: data only in the cycle after CE1, junk otherwise.
    always @(posedge CLK) Q1 <= CE1 ? word_at(A1) : DATA_W'($urandom);

    // Reference model state
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W:0]   exp_beat_q[$];
    bit                busy = 0, done_due = 0, prev_stall = 0, hs_seen = 0, rnd_ready = 0;
    logic [DATA_W:0]   prev_beat;
    logic [ADDR_W-1:0] last_a1;
    int cyc = 0, outstanding = 0, ce1_cnt = 0, beat_cnt = 0;
    int hs_cyc = 0, first_beat_cyc = -1, last_beat_cyc = -1, done_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred, expected none (cycle %0d)", name, cyc);
    endtask

    task automatic monitor();
        logic [ADDR_W-1:0] a;
        cyc++;
        hs_seen = 0;
        if (RST) begin
            check("req_ready_in_rst", req_ready, 0);
            return;
        end
        check("done", done, done_due);
        if (done) done_cyc = cyc;
        done_due = 0;
        check("req_ready", req_ready, !busy);
        if (CE1) begin
            ce1_cnt++;
            last_a1 = A1;
            if (exp_addr_q.size() == 0) note_fail("spurious_ce1");
            else check("a1", A1, exp_addr_q.pop_front());
            outstanding++;
            check("credit_bound", outstanding <= DEPTH, 1);
        end
        if (out_valid) begin
            if (exp_beat_q.size() == 0) note_fail("spurious_out_valid");
            if (prev_stall) check("hold_stable", {out_last, out_data}, prev_beat);
            if (out_ready && exp_beat_q.size() != 0) begin
                check("beat", {out_last, out_data}, exp_beat_q.pop_front());
                beat_cnt++;
                outstanding--;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                if (out_last) begin
                    done_due = 1;
                    busy = 0;
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = {out_last, out_data};
        if (req_valid && req_ready) begin
            hs_seen = 1;
            hs_cyc  = cyc;
            if (req_len == '0) begin
                done_due = 1;
            end else begin
                busy = 1;
                for (int i = 0; i < int'(req_len); i++) begin
                    a = req_addr + ADDR_W'(i);
                    exp_addr_q.push_back(a);
                    exp_beat_q.push_back({(i == int'(req_len) - 1), word_at(a)});
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic clear_stats();
        ce1_cnt = 0; beat_cnt = 0; first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    endtask

    task automatic do_req(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        int budget = 0;
        req_addr  = a;
        req_len   = l;
        req_valid = 1;
        do begin
            tick();
            budget++;
        end while (!hs_seen && budget < 100);
        if (!hs_seen) note_fail("req_timeout");
        req_valid = 0;
        req_addr  = ADDR_W'($urandom);
        req_len   = LEN_W'($urandom);
    endtask

    task automatic wait_idle();
        int budget = 0;
        while ((busy || done_due) && budget < 300) begin
            tick();
            budget++;
        end
        if (busy || done_due) note_fail("idle_timeout");
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        int                stall;
        int                exp_beats;
        int                exp_ce1;
        int                exp_lat;
        logic [ADDR_W-1:0] exp_last_a1;
        int                exp_stall_ce1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{18'h00010, 19'd4, 0,  4, 4,  2, 18'h00013, 0};
        vecs[1] = '{18'h3FFFE, 19'd4, 0,  4, 4,  2, 18'h00001, 0};
        vecs[2] = '{18'h00020, 19'd8, 10, 8, 8, -1, 18'h00027, 4};
        vecs[3] = '{18'h00000, 19'd0, 0,  0, 0, -1, 18'h00000, 0};
        vecs[4] = '{18'h3FFFF, 19'd1, 0,  1, 1,  2, 18'h3FFFF, 0};
        vecs[5] = '{18'h01000, 19'd3, 2,  3, 3, -1, 18'h01002, 2};

        RST = 1; req_valid = 0; req_addr = '0; req_len = '0; out_ready = 0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_ce1", CE1, 0);
        check("rst_a1", A1, 0);
        check("rst_req_ready", req_ready, 0);
        @(posedge CLK); #1;
        RST = 0;
        tick();

        foreach (vecs[i]) begin
            clear_stats();
            out_ready = (vecs[i].stall == 0);
            do_req(vecs[i].addr, vecs[i].len);
            if (vecs[i].stall > 0) begin
                repeat (vecs[i].stall) tick();
                check("stall_ce1", ce1_cnt, vecs[i].exp_stall_ce1);
                out_ready = 1;
            end
            wait_idle();
            check("beats", beat_cnt, vecs[i].exp_beats);
            check("ce1_total", ce1_cnt, vecs[i].exp_ce1);
            if (vecs[i].exp_lat >= 0) check("latency", first_beat_cyc - hs_cyc, vecs[i].exp_lat);
            if (vecs[i].len != '0) begin
                check("last_a1", last_a1, vecs[i].exp_last_a1);
                check("done_after_last", done_cyc - last_beat_cyc, 1);
            end else begin
                check("done_after_zero", done_cyc - hs_cyc, 1);
            end
            if (vecs[i].stall == 0 && vecs[i].len != '0)
                check("no_gaps", last_beat_cyc - first_beat_cyc, int'(vecs[i].len) - 1);
            tick();
        end

        // Back-to-back: second request presented in the done cycle.
        begin
            int budget = 0;
            clear_stats();
            out_ready = 1;
            do_req(18'h00040, 19'd3);
            while (!done_due && budget < 50) begin
                tick();
                budget++;
            end
            if (!done_due) note_fail("b2b_first_timeout");
            clear_stats();
            do_req(18'h00080, 19'd2);
            check("b2b_accept_in_done", hs_cyc, done_cyc);
            wait_idle();
            check("b2b_latency", first_beat_cyc - hs_cyc, 2);
            check("b2b_beats", beat_cnt, 2);
        end

        // Reset after three of six beats.
        begin
            int budget = 0;
            clear_stats();
            out_ready = 1;
            do_req(18'h00200, 19'd6);
            while (beat_cnt < 3 && budget < 50) begin
                tick();
                budget++;
            end
            check("pre_rst_beats", beat_cnt, 3);
            RST = 1;
            tick();
            RST = 0;
            exp_addr_q.delete();
            exp_beat_q.delete();
            busy = 0; done_due = 0; prev_stall = 0; outstanding = 0;
            @(negedge CLK);
            check("post_rst_out_valid", out_valid, 0);
            check("post_rst_ce1", CE1, 0);
            check("post_rst_req_ready", req_ready, 1);
            check("post_rst_done", done, 0);
            monitor();
            @(posedge CLK); #1;
            clear_stats();
            do_req(18'h00100, 19'd2);
            wait_idle();
            check("post_rst_burst_beats", beat_cnt, 2);
            check("post_rst_burst_latency", first_beat_cyc - hs_cyc, 2);
        end

        // Random bursts with random backpressure.
        rnd_ready = 1;
        for (int n = 0; n < 40; n++) begin
            logic [ADDR_W-1:0] a;
            logic [LEN_W-1:0]  l;
            a = ($urandom_range(0, 3) == 0) ? (18'h3FFF0 + ADDR_W'($urandom_range(0, 15)))
                                            : ADDR_W'($urandom);
            l = LEN_W'($urandom_range(0, 12));
            clear_stats();
            do_req(a, l);
            wait_idle();
            check("rnd_beats", beat_cnt, int'(l));
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_ready = 0;
        out_ready = 1;
        tick();
        check("end_queue_empty", exp_beat_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
